// File: rtl/seq_pkg.sv
// Shared definitions for the three-step sequencer decoder.
//   LEN_W_DEF   : default width of the run-length field
//   seq_state_t : decoder FSM states
//   step_next   : 0 -> 1 -> 2 -> 0 step advance
`ifndef BITS
`define BITS 16
`endif

package seq_pkg;

  localparam int LEN_W_DEF = 24;

  typedef enum logic [2:0] {
    SYNC,
    CAP0,
    CAP1,
    CAP2,
    LOCKED
  } seq_state_t;

  function automatic logic [1:0] step_next(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/run_meter.sv
// Change detector and saturating run-length counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   sig        : stepped input signal
//   change     : sig differs from the value held on the previous cycle
//   run_len    : cycles the previous value has been held (valid at a change)
//   run_val    : value of the run that a change terminates
//   saturated  : counter is pinned at its maximum
`ifndef BITS
`define BITS 16
`endif

module run_meter
  import seq_pkg::*;
#(
  parameter int BITS  = `BITS,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [BITS-1:0] sig,
  output logic                   change,
  output logic [LEN_W-1:0]       run_len,
  output logic signed [BITS-1:0] run_val,
  output logic                   saturated
);

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  logic signed [BITS-1:0] prev;
  logic [LEN_W-1:0]       cnt;

  assign change    = (sig != prev);
  assign run_len   = cnt;
  assign run_val   = prev;
  assign saturated = (cnt == CNT_MAX);

  // The cycle that brings a new value counts as the first cycle of its run.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      cnt  <= '0;
    end else begin
      prev <= sig;
      if (change)
        cnt <= LEN_W'(1);
      else if (!saturated)
        cnt <= cnt + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq3_decode.sv
// Recovers the three levels and the step length of a three-step sequencer
// from its output, and tracks which step is currently on the line.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   sigIn      : stepped signal under observation
//   l0, l1, l2 : captured levels (held after lock is lost)
//   len        : recovered step length, run cycles minus one
//   locked     : pattern confirmed
//   step       : index of the level currently on sigIn while locked, else 0
`ifndef BITS
`define BITS 16
`endif

module seq3_decode
  import seq_pkg::*;
#(
  parameter int BITS  = `BITS,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [BITS-1:0]  sigIn,
  output logic signed [BITS-1:0]  l0,
  output logic signed [BITS-1:0]  l1,
  output logic signed [BITS-1:0]  l2,
  output logic signed [LEN_W-1:0] len,
  output logic                    locked,
  output logic [1:0]              step
);

  logic                   change;
  logic [LEN_W-1:0]       run_len;
  logic signed [BITS-1:0] run_val;
  logic                   saturated;

  run_meter #(
    .BITS  (BITS),
    .LEN_W (LEN_W)
  ) u_meter (
    .clk       (clk),
    .rst       (rst),
    .sig       (sigIn),
    .change    (change),
    .run_len   (run_len),
    .run_val   (run_val),
    .saturated (saturated)
  );

  seq_state_t             state, state_nx;
  logic signed [BITS-1:0] cand0, cand1;
  logic [LEN_W-1:0]       nref;
  logic                   cap0_en, cap1_en, lock_en;
  logic                   locked_nx;
  logic [1:0]             step_nx;
  logic signed [BITS-1:0] exp_lvl;
  logic                   len_ok;

  assign len_ok = (run_len == nref);

  always_comb begin
    case (step)
      2'd0:    exp_lvl = l0;
      2'd1:    exp_lvl = l1;
      default: exp_lvl = l2;
    endcase
  end

  always_comb begin
    state_nx  = state;
    cap0_en   = 1'b0;
    cap1_en   = 1'b0;
    lock_en   = 1'b0;
    locked_nx = locked;
    step_nx   = step;
    case (state)
      SYNC: begin
        // The run in progress started before we were watching; drop it.
        if (change) state_nx = CAP0;
      end
      CAP0: begin
        if (change) begin
          cap0_en  = 1'b1;
          state_nx = CAP1;
        end
      end
      CAP1: begin
        if (change) begin
          if (len_ok) begin
            cap1_en  = 1'b1;
            state_nx = CAP2;
          end else begin
            state_nx = SYNC;
          end
        end
      end
      CAP2: begin
        if (change) begin
          if (len_ok) begin
            lock_en   = 1'b1;
            locked_nx = 1'b1;
            step_nx   = 2'd0;
            state_nx  = LOCKED;
          end else begin
            state_nx = SYNC;
          end
        end
      end
      LOCKED: begin
        if (change) begin
          if (len_ok && (run_val == exp_lvl))
            step_nx = step_next(step);
          else
            state_nx = SYNC;
        end
      end
      default: state_nx = SYNC;
    endcase
    // A value held past the counter range can't belong to a valid pattern.
    if (saturated && !change) state_nx = SYNC;
    if (state_nx != LOCKED) begin
      locked_nx = 1'b0;
      step_nx   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SYNC;
      locked <= 1'b0;
      step   <= 2'd0;
      l0     <= '0;
      l1     <= '0;
      l2     <= '0;
      len    <= '0;
    end else begin
      state  <= state_nx;
      locked <= locked_nx;
      step   <= step_nx;
      // The third candidate is taken straight from the meter so that all
      // outputs update on the locking edge together.
      if (lock_en) begin
        l0  <= cand0;
        l1  <= cand1;
        l2  <= run_val;
        len <= $signed(nref - LEN_W'(1));
      end
    end
  end

  // Candidate storage is only meaningful once the FSM has walked through the
  // capture states after a reset, so it carries no reset of its own.
  always_ff @(posedge clk) begin
    if (cap0_en) begin
      cand0 <= run_val;
      nref  <= run_len;
    end
    if (cap1_en) cand1 <= run_val;
  end

endmodule

// File: tb/tb_seq3_decode.sv
module tb_seq3_decode;

  localparam int BITS  = 16;
  localparam int LEN_W = 6;
  localparam int SAT   = (1 << LEN_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [BITS-1:0]  sigIn;
  logic signed [BITS-1:0]  l0, l1, l2;
  logic signed [LEN_W-1:0] len;
  logic                    locked;
  logic [1:0]              step;

  always #5 clk = ~clk;

  seq3_decode #(.BITS(BITS), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .sigIn  (sigIn),
    .l0     (l0),
    .l1     (l1),
    .l2     (l2),
    .len    (len),
    .locked (locked),
    .step   (step)
  );

  typedef struct packed {
    logic                    locked;
    logic [1:0]              step;
    logic signed [BITS-1:0]  l0;
    logic signed [BITS-1:0]  l1;
    logic signed [BITS-1:0]  l2;
    logic signed [LEN_W-1:0] len;
  } obs_t;

  obs_t expq[$];
  obs_t mon_e, mon_a;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: works on whole runs (value, length) of the input.
  int m_prev, m_held, m_phase, m_nref, m_step, m_len;
  bit m_locked;
  int m_cand[3];
  int m_lvl[3];

  task automatic m_desync();
    m_phase  = -1;
    m_locked = 1'b0;
    m_step   = 0;
  endtask

  task automatic model_edge(input int s, input bit r);
    int v, n;
    if (r) begin
      m_prev = 0;
      m_held = 0;
      m_desync();
      m_lvl  = '{0, 0, 0};
      m_len  = 0;
    end else begin
      if (s != m_prev) begin
        v      = m_prev;
        n      = m_held;
        m_held = 1;
        if (m_phase < 0) begin
          m_phase = 0;
        end else if (m_phase == 0) begin
          m_cand[0] = v;
          m_nref    = n;
          m_phase   = 1;
        end else if (n != m_nref) begin
          m_desync();
        end else if (m_phase < 3) begin
          m_cand[m_phase] = v;
          m_phase++;
          if (m_phase == 3) begin
            m_lvl    = m_cand;
            m_len    = m_nref - 1;
            m_locked = 1'b1;
            m_step   = 0;
          end
        end else if (v != m_lvl[m_step]) begin
          m_desync();
        end else begin
          m_step = (m_step + 1) % 3;
        end
      end else if (m_held == SAT) begin
        m_desync();
      end else begin
        m_held++;
      end
      m_prev = s;
    end
  endtask

  function automatic obs_t snap();
    obs_t o;
    o.locked = m_locked;
    o.step   = 2'(m_step);
    o.l0     = BITS'(m_lvl[0]);
    o.l1     = BITS'(m_lvl[1]);
    o.l2     = BITS'(m_lvl[2]);
    o.len    = LEN_W'(m_len);
    return o;
  endfunction

  task automatic drive(input int v, input bit r);
    @(posedge clk);
    #2;
    sigIn = BITS'(v);
    rst   = r;
    model_edge(v, r);
    expq.push_back(snap());
  endtask

  task automatic play(input int v, input int n);
    for (int i = 0; i < n; i++) drive(v, 1'b0);
  endtask

  task automatic period(input int a, input int b, input int c, input int n);
    play(a, n);
    play(b, n);
    play(c, n);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every edge presents a new output set; compare against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        mon_a = {locked, step, l0, l1, l2, len};
        n_cmp++;
        if (mon_a !== mon_e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: got lk=%0b st=%0d l=%0d,%0d,%0d len=%0d, expected lk=%0b st=%0d l=%0d,%0d,%0d len=%0d",
                   $time, mon_a.locked, mon_a.step, mon_a.l0, mon_a.l1, mon_a.l2, mon_a.len,
                   mon_e.locked, mon_e.step, mon_e.l0, mon_e.l1, mon_e.l2, mon_e.len);
        end
      end
    end
  end

  int lv[3];
  int rl, this_len;

  initial begin
    rst   = 1'b1;
    sigIn = '0;
    model_edge(0, 1'b1);
    expq.push_back(snap());

    // Reset state
    drive(0, 1'b1);
    drive(0, 1'b1);
    drive(100, 1'b0);
    check("reset_locked", locked, 0);
    check("reset_len", len, 0);
    check("reset_l0", l0, 0);

    // Lock on 100,-50,7 with runs of 5
    play(100, 4);
    play(-50, 5);
    play(7, 5);
    for (int p = 0; p < 3; p++) period(100, -50, 7, 5);
    drive(100, 1'b0);
    check("lock_locked", locked, 1);
    check("lock_l0", l0, 100);
    check("lock_l1", l1, -50);
    check("lock_l2", l2, 7);
    check("lock_len", len, 4);

    // Shortened run drops lock, captured values hold, then relock
    play(100, 4);
    play(-50, 3);
    drive(7, 1'b0);
    drive(7, 1'b0);
    check("short_locked", locked, 0);
    check("short_l0", l0, 100);
    check("short_l1", l1, -50);
    check("short_l2", l2, 7);
    check("short_len", len, 4);
    play(7, 3);
    for (int p = 0; p < 3; p++) period(100, -50, 7, 5);
    drive(100, 1'b0);
    check("relock_locked", locked, 1);

    // Frozen input saturates the counter
    play(100, 4);
    play(-50, 5);
    play(7, SAT + 10);
    drive(7, 1'b0);
    check("freeze_locked", locked, 0);

    // Equal adjacent levels never lock
    for (int p = 0; p < 6; p++) period(5, 5, 9, 3);
    drive(5, 1'b0);
    check("equal_locked", locked, 0);

    // Reset while locked, then a len=0 pattern
    for (int p = 0; p < 3; p++) period(100, -50, 7, 5);
    drive(100, 1'b1);
    drive(1, 1'b0);
    check("rst_locked", locked, 0);
    check("rst_step", step, 0);
    check("rst_l0", l0, 0);
    check("rst_l1", l1, 0);
    check("rst_l2", l2, 0);
    check("rst_len", len, 0);
    drive(2, 1'b0);
    drive(3, 1'b0);
    for (int p = 0; p < 3; p++) period(1, 2, 3, 1);
    drive(1, 1'b0);
    check("len0_locked", locked, 1);
    check("len0_len", len, 0);
    check("len0_l0", l0, 1);
    check("len0_l2", l2, 3);

    // Wrong level order at correct length
    for (int p = 0; p < 3; p++) period(100, -50, 7, 5);
    play(100, 5);
    play(3, 5);
    drive(7, 1'b0);
    drive(7, 1'b0);
    check("order_locked", locked, 0);

    // Randomized patterns with occasional length glitches and resets
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < 3; k++) lv[k] = int'($urandom_range(0, 12)) - 6;
      rl = int'($urandom_range(1, 8));
      for (int p = 0; p < 5; p++) begin
        for (int k = 0; k < 3; k++) begin
          this_len = rl;
          if ($urandom_range(0, 19) == 0) this_len = rl + 1;
          if ($urandom_range(0, 19) == 0 && rl > 1) this_len = rl - 1;
          play(lv[k], this_len);
        end
        if ($urandom_range(0, 29) == 0) drive(lv[0], 1'b1);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
